// File: rtl/pwm_pkg.sv
// Shared definitions for PWM sequencers: ramp state encoding and compare-width helper.
package pwm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_UP,
        ST_DOWN
    } ramp_state_t;

    localparam int DEFAULT_RESOLUTION = 8;

    // Compare values need one extra bit so that 2^RESOLUTION (100% duty) is reachable.
    function automatic int compare_width(input int resolution);
        return resolution + 1;
    endfunction

endpackage

// File: rtl/pwm_period_tick.sv
// Free-running period counter 0..r_top; r_top picks up a new top only at period start.
module pwm_period_tick #(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_top,
    output logic             o_tick
);

    logic [WIDTH-1:0] count;
    logic [WIDTH-1:0] r_top;

    assign o_tick = (count == r_top);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            count <= '0;
            r_top <= '0;
        end else begin
            if (count == '0) begin
                r_top <= i_top;
            end
            if (o_tick) begin
                count <= '0;
            end else begin
                count <= count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/pwm_ramp_ctrl.sv
// Ramps a PWM compare value toward a target in fixed steps, one step per (dwell+1) periods,
// optionally bouncing between 0 and the target forever.
module pwm_ramp_ctrl
    import pwm_pkg::*;
#(
    parameter int RESOLUTION  = DEFAULT_RESOLUTION,
    parameter int DWELL_WIDTH = 16
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic [RESOLUTION-1:0]   i_top,
    input  logic                    i_top_valid,
    input  logic [RESOLUTION:0]     i_target,
    input  logic [RESOLUTION-1:0]   i_step,
    input  logic [DWELL_WIDTH-1:0]  i_dwell,
    input  logic                    i_breathe,
    input  logic                    i_cmd_valid,
    input  logic                    i_stop,
    output logic [RESOLUTION-1:0]   o_top,
    output logic                    o_top_valid,
    output logic [RESOLUTION:0]     o_compare,
    output logic                    o_compare_valid,
    output logic                    o_busy,
    output logic                    o_done
);

    localparam int CW = compare_width(RESOLUTION);
    localparam int AW = RESOLUTION + 2;
    localparam logic [CW-1:0] FULL_SCALE = CW'(1) << RESOLUTION;

    ramp_state_t            state, state_next;
    logic [CW-1:0]          target_r, target_next;
    logic [RESOLUTION-1:0]  step_r, step_next;
    logic [DWELL_WIDTH-1:0] dwell_r, dwell_next;
    logic                   breathe_r, breathe_next;
    logic [DWELL_WIDTH-1:0] dwell_cnt, dwell_cnt_next;
    logic [CW-1:0]          compare_next;
    logic                   compare_valid_next;
    logic                   done_next;
    logic                   tick;

    logic [CW-1:0]          target_clamped;
    logic [RESOLUTION-1:0]  step_eff;
    logic [CW-1:0]          floor_value;
    logic [AW-1:0]          sum, diff;
    logic [CW-1:0]          up_value, down_value;

    pwm_period_tick #(.WIDTH(RESOLUTION)) u_period_tick (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_top  (o_top),
        .o_tick (tick)
    );

    assign target_clamped = (i_target > FULL_SCALE) ? FULL_SCALE : i_target;
    assign step_eff       = (i_step == '0) ? RESOLUTION'(1) : i_step;
    assign floor_value    = breathe_r ? '0 : target_r;
    assign sum            = AW'(o_compare) + AW'(step_r);
    assign diff           = AW'(o_compare) - AW'(step_r);
    assign up_value       = (sum >= AW'(target_r)) ? target_r : sum[CW-1:0];
    // compare - step < floor, rearranged so the underflow case needs no separate test.
    assign down_value     = (AW'(o_compare) < (AW'(step_r) + AW'(floor_value))) ? floor_value : diff[CW-1:0];
    assign o_busy         = (state != ST_IDLE);

    always_comb begin
        state_next         = state;
        target_next        = target_r;
        step_next          = step_r;
        dwell_next         = dwell_r;
        breathe_next       = breathe_r;
        dwell_cnt_next     = dwell_cnt;
        compare_next       = o_compare;
        compare_valid_next = 1'b0;
        done_next          = 1'b0;

        if (i_stop) begin
            state_next     = ST_IDLE;
            dwell_cnt_next = '0;
        end else if (i_cmd_valid) begin
            target_next    = target_clamped;
            step_next      = step_eff;
            dwell_next     = i_dwell;
            breathe_next   = i_breathe;
            dwell_cnt_next = '0;
            if (target_clamped > o_compare) begin
                state_next = ST_UP;
            end else if (target_clamped < o_compare) begin
                state_next = ST_DOWN;
            end else if (i_breathe && (target_clamped != '0)) begin
                state_next = ST_DOWN;
            end else begin
                state_next = ST_IDLE;
                done_next  = 1'b1;
            end
        end else if ((state != ST_IDLE) && tick) begin
            if (dwell_cnt == dwell_r) begin
                dwell_cnt_next     = '0;
                compare_valid_next = 1'b1;
                unique case (state)
                    ST_UP: begin
                        compare_next = up_value;
                        if (up_value == target_r) begin
                            if (breathe_r) begin
                                state_next = ST_DOWN;
                            end else begin
                                state_next = ST_IDLE;
                                done_next  = 1'b1;
                            end
                        end
                    end
                    ST_DOWN: begin
                        compare_next = down_value;
                        if (down_value == floor_value) begin
                            if (breathe_r) begin
                                state_next = ST_UP;
                            end else begin
                                state_next = ST_IDLE;
                                done_next  = 1'b1;
                            end
                        end
                    end
                    default: begin
                        state_next = ST_IDLE;
                    end
                endcase
            end else begin
                dwell_cnt_next = dwell_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state           <= ST_IDLE;
            target_r        <= '0;
            step_r          <= '0;
            dwell_r         <= '0;
            breathe_r       <= 1'b0;
            dwell_cnt       <= '0;
            o_compare       <= '0;
            o_compare_valid <= 1'b0;
            o_done          <= 1'b0;
            o_top           <= '0;
            o_top_valid     <= 1'b0;
        end else begin
            state           <= state_next;
            target_r        <= target_next;
            step_r          <= step_next;
            dwell_r         <= dwell_next;
            breathe_r       <= breathe_next;
            dwell_cnt       <= dwell_cnt_next;
            o_compare       <= compare_next;
            o_compare_valid <= compare_valid_next;
            o_done          <= done_next;
            o_top_valid     <= i_top_valid;
            if (i_top_valid) begin
                o_top <= i_top;
            end
        end
    end

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Directed self-checking bench for pwm_ramp_ctrl: one-shot ramps, breathe, clamping,
// preemption, stop-vs-command priority and asynchronous reset.
module tb_pwm_ramp_ctrl;

    logic        clk;
    logic        rst;
    logic [7:0]  top;
    logic        top_valid;
    logic [8:0]  target;
    logic [7:0]  step;
    logic [15:0] dwell;
    logic        breathe;
    logic        cmd_valid;
    logic        stop;
    logic [7:0]  o_top;
    logic        o_top_valid;
    logic [8:0]  o_compare;
    logic        o_compare_valid;
    logic        o_busy;
    logic        o_done;

    int checks = 0;
    int errors = 0;

    pwm_ramp_ctrl #(.RESOLUTION(8), .DWELL_WIDTH(16)) dut (
        .i_clk           (clk),
        .i_rst           (rst),
        .i_top           (top),
        .i_top_valid     (top_valid),
        .i_target        (target),
        .i_step          (step),
        .i_dwell         (dwell),
        .i_breathe       (breathe),
        .i_cmd_valid     (cmd_valid),
        .i_stop          (stop),
        .o_top           (o_top),
        .o_top_valid     (o_top_valid),
        .o_compare       (o_compare),
        .o_compare_valid (o_compare_valid),
        .o_busy          (o_busy),
        .o_done          (o_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [8:0] t, input logic [7:0] s, input logic [15:0] d, input logic b);
        @(negedge clk);
        target    = t;
        step      = s;
        dwell     = d;
        breathe   = b;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic setTop(input logic [7:0] t);
        @(negedge clk);
        top       = t;
        top_valid = 1'b1;
        @(negedge clk);
        top_valid = 1'b0;
        checkOutput("top_valid", 32'(o_top_valid), 32'd1);
        checkOutput("top_value", 32'(o_top), 32'(t));
        @(negedge clk);
        checkOutput("top_valid_pulse", 32'(o_top_valid), 32'd0);
        checkOutput("top_hold", 32'(o_top), 32'(t));
    endtask

    task automatic doReset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Waits (bounded) for the next compare_valid pulse; gap counts clocks since the call.
    task automatic waitStep(input string tag, output logic [8:0] value, output logic done, output int gap);
        bit found = 1'b0;
        value = '0;
        done  = 1'b0;
        gap   = 0;
        while (!found && gap < 2000) begin
            @(negedge clk);
            gap++;
            if (o_compare_valid) begin
                found = 1'b1;
                value = o_compare;
                done  = o_done;
            end
        end
        if (!found) checkOutput({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic countPulses(input int cycles, output int pulses);
        pulses = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (o_compare_valid || o_done) pulses++;
        end
    endtask

    initial begin
        logic [8:0] value;
        logic       done;
        int         gap;
        int         pulses;
        int         exp1[3] = '{4, 8, 10};
        int         exp2[3] = '{6, 2, 1};
        int         exp3[6] = '{3, 4, 1, 0, 3, 4};
        int         exp4[3] = '{255, 254, 253};

        rst = 1'b1; top = '0; top_valid = 1'b0; target = '0; step = '0;
        dwell = '0; breathe = 1'b0; cmd_valid = 1'b0; stop = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset_compare", 32'(o_compare), 32'd0);
        checkOutput("reset_busy", 32'(o_busy), 32'd0);
        checkOutput("reset_done", 32'(o_done), 32'd0);
        checkOutput("reset_valid", 32'(o_compare_valid), 32'd0);
        checkOutput("reset_top", 32'(o_top), 32'd0);
        rst = 1'b0;

        $display("[TB] one-shot up: top=3 target=10 step=4 dwell=0");
        setTop(8'd3);
        applyStimulus(9'd10, 8'd4, 16'd0, 1'b0);
        checkOutput("t1_busy", 32'(o_busy), 32'd1);
        for (int i = 0; i < 3; i++) begin
            waitStep("t1_step", value, done, gap);
            checkOutput("t1_value", 32'(value), 32'(exp1[i]));
            if (i > 0) checkOutput("t1_gap", 32'(gap), 32'd4);
            checkOutput("t1_done", 32'(done), (i == 2) ? 32'd1 : 32'd0);
        end
        checkOutput("t1_busy_end", 32'(o_busy), 32'd0);
        @(negedge clk);
        checkOutput("t1_done_pulse", 32'(o_done), 32'd0);
        checkOutput("t1_valid_pulse", 32'(o_compare_valid), 32'd0);

        $display("[TB] one-shot down: target=1 step=4 dwell=1");
        applyStimulus(9'd1, 8'd4, 16'd1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            waitStep("t2_step", value, done, gap);
            checkOutput("t2_value", 32'(value), 32'(exp2[i]));
            if (i > 0) checkOutput("t2_gap", 32'(gap), 32'd8);
            checkOutput("t2_done", 32'(done), (i == 2) ? 32'd1 : 32'd0);
        end

        $display("[TB] equal target one-shot");
        applyStimulus(9'd1, 8'd4, 16'd0, 1'b0);
        checkOutput("eq_done", 32'(o_done), 32'd1);
        checkOutput("eq_busy", 32'(o_busy), 32'd0);
        checkOutput("eq_valid", 32'(o_compare_valid), 32'd0);
        @(negedge clk);
        checkOutput("eq_done_pulse", 32'(o_done), 32'd0);

        $display("[TB] breathe: top=1 target=4 step=3");
        doReset();
        setTop(8'd1);
        applyStimulus(9'd4, 8'd3, 16'd0, 1'b1);
        for (int i = 0; i < 6; i++) begin
            waitStep("t3_step", value, done, gap);
            checkOutput("t3_value", 32'(value), 32'(exp3[i]));
            if (i > 0) checkOutput("t3_gap", 32'(gap), 32'd2);
            checkOutput("t3_done", 32'(done), 32'd0);
        end
        @(negedge clk);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        checkOutput("t3_stop_busy", 32'(o_busy), 32'd0);
        countPulses(10, pulses);
        checkOutput("t3_stop_pulses", 32'(pulses), 32'd0);
        checkOutput("t3_stop_hold", 32'(o_compare), 32'd4);

        $display("[TB] clamp: top=255 target=300, then step=0");
        doReset();
        setTop(8'd255);
        applyStimulus(9'd300, 8'd200, 16'd0, 1'b0);
        waitStep("t4_step", value, done, gap);
        checkOutput("t4_first", 32'(value), 32'd200);
        checkOutput("t4_first_done", 32'(done), 32'd0);
        waitStep("t4_step", value, done, gap);
        checkOutput("t4_clamped", 32'(value), 32'd256);
        checkOutput("t4_clamp_gap", 32'(gap), 32'd256);
        checkOutput("t4_clamp_done", 32'(done), 32'd1);
        setTop(8'd3);
        applyStimulus(9'd253, 8'd0, 16'd0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            waitStep("t4_zero_step", value, done, gap);
            checkOutput("t4_zero_value", 32'(value), 32'(exp4[i]));
            if (i > 0) checkOutput("t4_zero_gap", 32'(gap), 32'd4);
            checkOutput("t4_zero_done", 32'(done), (i == 2) ? 32'd1 : 32'd0);
        end

        $display("[TB] preemption, stop priority, async reset");
        doReset();
        setTop(8'd3);
        applyStimulus(9'd100, 8'd10, 16'd0, 1'b0);
        waitStep("t5_step", value, done, gap);
        checkOutput("t5_first", 32'(value), 32'd10);
        waitStep("t5_step", value, done, gap);
        checkOutput("t5_second", 32'(value), 32'd20);
        applyStimulus(9'd5, 8'd5, 16'd0, 1'b0);
        checkOutput("t5_preempt_busy", 32'(o_busy), 32'd1);
        waitStep("t5_preempt_step", value, done, gap);
        checkOutput("t5_preempt_value", 32'(value), 32'd15);
        @(negedge clk);
        stop      = 1'b1;
        cmd_valid = 1'b1;
        target    = 9'd200;
        step      = 8'd10;
        @(negedge clk);
        stop      = 1'b0;
        cmd_valid = 1'b0;
        checkOutput("t5_stopcmd_busy", 32'(o_busy), 32'd0);
        checkOutput("t5_stopcmd_done", 32'(o_done), 32'd0);
        countPulses(12, pulses);
        checkOutput("t5_stopcmd_pulses", 32'(pulses), 32'd0);
        checkOutput("t5_stopcmd_hold", 32'(o_compare), 32'd15);
        applyStimulus(9'd25, 8'd10, 16'd0, 1'b0);
        waitStep("t5_restart", value, done, gap);
        checkOutput("t5_restart_value", 32'(value), 32'd25);
        checkOutput("t5_restart_done", 32'(done), 32'd1);
        applyStimulus(9'd200, 8'd10, 16'd0, 1'b0);
        waitStep("t5_ramp", value, done, gap);
        checkOutput("t5_ramp_value", 32'(value), 32'd35);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checkOutput("async_compare", 32'(o_compare), 32'd0);
        checkOutput("async_busy", 32'(o_busy), 32'd0);
        checkOutput("async_top", 32'(o_top), 32'd0);
        checkOutput("async_valid", 32'(o_compare_valid), 32'd0);
        checkOutput("async_done", 32'(o_done), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        countPulses(10, pulses);
        checkOutput("release_pulses", 32'(pulses), 32'd0);
        checkOutput("release_compare", 32'(o_compare), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
